// File: rtl/ep_cmd_sequencer.sv
// ep_cmd_sequencer
// ----------------
// Command sequencer between host WireIn/WireOut endpoints and an unsigned
// 32-bit arithmetic datapath. A new command is recognised when the tag field
// of cmd_word differs from the last accepted tag. The command runs for one
// cycle (ADD/SUB/ACC/CLR/illegal) or 32 cycles (MUL, shift-add). The result
// and status are then posted for the host to poll.
//
// Ports:
//   okClk       - sole clock, rising edge
//   rst_n       - asynchronous active-low reset
//   cmd_word    - [31:24] tag, [3:0] opcode, other bits ignored
//   op_a, op_b  - operands, latched when the command is accepted
//   status_word - [31:24] done_tag, [23:16] acc_tag, [3] err, [2] ovf,
//                 [1] done, [0] busy
//   result_word - last posted result
//   acc_word    - accumulator contents
module ep_cmd_sequencer #(
   parameter logic SATURATE = 1'b0
) (
   input  logic        okClk,
   input  logic        rst_n,
   input  logic [31:0] cmd_word,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] status_word,
   output logic [31:0] result_word,
   output logic [31:0] acc_word
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_ACC = 4'd3;
   localparam logic [3:0] OP_CLR = 4'd4;

   state_t      state_r,    state_n;
   logic [3:0]  opcode_r,   opcode_n;
   logic [31:0] a_r,        a_n;
   logic [31:0] b_r,        b_n;
   logic [7:0]  acc_tag_r,  acc_tag_n;
   logic [7:0]  done_tag_r, done_tag_n;
   logic        busy_r,     busy_n;
   logic        done_r,     done_n;
   logic        err_r,      err_n;
   logic        ovf_r,      ovf_n;
   logic [31:0] result_r,   result_n;
   logic [31:0] acc_r,      acc_n;
   logic [4:0]  bit_cnt_r,  bit_cnt_n;
   logic [63:0] prod_r,     prod_n;
   logic [63:0] mcand_r,    mcand_n;
   logic [31:0] mplier_r,   mplier_n;

   logic [32:0] add_sum_s;
   logic [32:0] sub_diff_s;
   logic [32:0] acc_sum_s;
   logic [31:0] add_res_s;
   logic [31:0] sub_res_s;
   logic [31:0] acc_res_s;
   logic        unused_cmd_bits_s;

   // Bits between the tag and the opcode carry no meaning for this block.
   assign unused_cmd_bits_s = ^cmd_word[23:4];

   // 33-bit unsigned arithmetic; bit 32 is carry (add) or borrow (sub).
   always_comb begin
      add_sum_s  = {1'b0, a_r} + {1'b0, b_r};
      sub_diff_s = {1'b0, a_r} - {1'b0, b_r};
      acc_sum_s  = {1'b0, acc_r} + {1'b0, a_r};
      if (SATURATE && add_sum_s[32]) begin
         add_res_s = 32'hFFFF_FFFF;
      end else begin
         add_res_s = add_sum_s[31:0];
      end
      if (SATURATE && sub_diff_s[32]) begin
         sub_res_s = 32'h0000_0000;
      end else begin
         sub_res_s = sub_diff_s[31:0];
      end
      if (SATURATE && acc_sum_s[32]) begin
         acc_res_s = 32'hFFFF_FFFF;
      end else begin
         acc_res_s = acc_sum_s[31:0];
      end
   end

   // Next-state and next-register computation for the sequencer FSM.
   always_comb begin
      state_n    = state_r;
      opcode_n   = opcode_r;
      a_n        = a_r;
      b_n        = b_r;
      acc_tag_n  = acc_tag_r;
      done_tag_n = done_tag_r;
      busy_n     = busy_r;
      done_n     = done_r;
      err_n      = err_r;
      ovf_n      = ovf_r;
      result_n   = result_r;
      acc_n      = acc_r;
      bit_cnt_n  = bit_cnt_r;
      prod_n     = prod_r;
      mcand_n    = mcand_r;
      mplier_n   = mplier_r;

      case (state_r)
         ST_IDLE: begin
            // Only the latest tag seen in IDLE matters; tags that came and
            // went while busy are never executed.
            if (cmd_word[31:24] != acc_tag_r) begin
               opcode_n  = cmd_word[3:0];
               a_n       = op_a;
               b_n       = op_b;
               acc_tag_n = cmd_word[31:24];
               busy_n    = 1'b1;
               done_n    = 1'b0;
               err_n     = 1'b0;
               ovf_n     = 1'b0;
               bit_cnt_n = 5'd0;
               prod_n    = 64'd0;
               mcand_n   = {32'd0, op_a};
               mplier_n  = op_b;
               state_n   = ST_EXEC;
            end else begin
               state_n = ST_IDLE;
            end
         end

         ST_EXEC: begin
            if (opcode_r == OP_MUL) begin
               // One multiplier bit per cycle: add the shifted multiplicand
               // when the current LSB of the multiplier is set.
               if (mplier_r[0]) begin
                  prod_n = prod_r + mcand_r;
               end else begin
                  prod_n = prod_r;
               end
               mcand_n   = {mcand_r[62:0], 1'b0};
               mplier_n  = {1'b0, mplier_r[31:1]};
               bit_cnt_n = bit_cnt_r + 5'd1;
               if (bit_cnt_r == 5'd31) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_EXEC;
               end
            end else begin
               state_n = ST_DONE;
            end
         end

         ST_DONE: begin
            case (opcode_r)
               OP_ADD: begin
                  result_n = add_res_s;
                  ovf_n    = add_sum_s[32];
               end
               OP_SUB: begin
                  result_n = sub_res_s;
                  ovf_n    = sub_diff_s[32];
               end
               OP_MUL: begin
                  result_n = prod_r[31:0];
                  ovf_n    = |prod_r[63:32];
               end
               OP_ACC: begin
                  result_n = acc_res_s;
                  acc_n    = acc_res_s;
                  ovf_n    = acc_sum_s[32];
               end
               OP_CLR: begin
                  result_n = 32'd0;
                  acc_n    = 32'd0;
                  ovf_n    = 1'b0;
               end
               default: begin
                  // Illegal opcode: flag it, keep result and accumulator.
                  err_n = 1'b1;
                  ovf_n = 1'b0;
               end
            endcase
            done_tag_n = acc_tag_r;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            state_n    = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any running command.
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         opcode_r   <= 4'd0;
         a_r        <= 32'd0;
         b_r        <= 32'd0;
         acc_tag_r  <= 8'd0;
         done_tag_r <= 8'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         ovf_r      <= 1'b0;
         result_r   <= 32'd0;
         acc_r      <= 32'd0;
         bit_cnt_r  <= 5'd0;
         prod_r     <= 64'd0;
         mcand_r    <= 64'd0;
         mplier_r   <= 32'd0;
      end else begin
         state_r    <= state_n;
         opcode_r   <= opcode_n;
         a_r        <= a_n;
         b_r        <= b_n;
         acc_tag_r  <= acc_tag_n;
         done_tag_r <= done_tag_n;
         busy_r     <= busy_n;
         done_r     <= done_n;
         err_r      <= err_n;
         ovf_r      <= ovf_n;
         result_r   <= result_n;
         acc_r      <= acc_n;
         bit_cnt_r  <= bit_cnt_n;
         prod_r     <= prod_n;
         mcand_r    <= mcand_n;
         mplier_r   <= mplier_n;
      end
   end

   assign status_word = {done_tag_r, acc_tag_r, 12'd0, err_r, ovf_r, done_r, busy_r};
   assign result_word = result_r;
   assign acc_word    = acc_r;

endmodule

// File: tb/tb_ep_cmd_sequencer.sv
module tb_ep_cmd_sequencer;

   logic        clk;
   logic        rst_n;
   logic [31:0] cmd_word;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] status_word, result_word, acc_word;
   logic [31:0] sat_status, sat_result, sat_acc;

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] res;
      logic [31:0] status;
      logic [31:0] acc;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic prev_done = 1'b0;

   ep_cmd_sequencer #(.SATURATE(1'b0)) dut (
      .okClk(clk), .rst_n(rst_n), .cmd_word(cmd_word), .op_a(op_a), .op_b(op_b),
      .status_word(status_word), .result_word(result_word), .acc_word(acc_word)
   );

   ep_cmd_sequencer #(.SATURATE(1'b1)) dut_sat (
      .okClk(clk), .rst_n(rst_n), .cmd_word(cmd_word), .op_a(op_a), .op_b(op_b),
      .status_word(sat_status), .result_word(sat_result), .acc_word(sat_acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] tag, input logic [31:0] res, input logic err,
                       input logic ovf, input logic [31:0] acc, input int ready);
      exp_t e;
      e.tag    = tag;
      e.res    = res;
      e.status = {tag, tag, 12'd0, err, ovf, 1'b1, 1'b0};
      e.acc    = acc;
      e.cyc    = ready;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      cmd_word = {tag, 20'd0, op};
      op_a     = a;
      op_b     = b;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Issue one command, check the busy/acc_tag response one cycle later,
   // and wait for the scoreboard to absorb the completion.
   task automatic issue(input logic [7:0] tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic err,
                        input logic ovf, input logic [31:0] acc, input int lat);
      @(negedge clk);
      drive(tag, op, a, b);
      push(tag, res, err, ovf, acc, cyc + lat);
      @(negedge clk);
      check("busy_after_accept", {31'd0, status_word[0]}, 32'd1);
      check("acc_tag_after_accept", {24'd0, status_word[23:16]}, {24'd0, tag});
      wait_drain();
   endtask

   // Monitor: every rising edge of done must match the head of the scoreboard.
   always @(negedge clk) begin
      if (status_word[1] && !prev_done) begin
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_done: actual tag=%h required no completion", status_word[31:24]);
         end else begin
            mon_e = exp_q.pop_front();
            check("status", status_word, mon_e.status);
            check("result", result_word, mon_e.res);
            check("acc", acc_word, mon_e.acc);
            check("done_cycle", cyc, mon_e.cyc);
         end
      end
      prev_done <= status_word[1];
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      drive(8'd0, 4'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      check("reset_status", status_word, 32'd0);
      check("reset_result", result_word, 32'd0);
      check("reset_acc", acc_word, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("tag0_not_accepted", status_word, 32'd0);

      issue(8'd1, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 32'd0, 3);
      issue(8'd2, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd0, 3);
      check("sat_sub_result", sat_result, 32'd0);
      check("sat_sub_ovf", {31'd0, sat_status[2]}, 32'd1);
      issue(8'd3, 4'd3, 32'd10, 32'd0, 32'd10, 1'b0, 1'b0, 32'd10, 3);
      issue(8'd4, 4'd3, 32'd20, 32'd0, 32'd30, 1'b0, 1'b0, 32'd30, 3);
      issue(8'd5, 4'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 3);

      // Tag changes while a MUL runs: only the last one is executed.
      @(negedge clk);
      c0 = cyc;
      drive(8'd6, 4'd2, 32'd3, 32'd4);
      push(8'd6, 32'd12, 1'b0, 1'b0, 32'd0, c0 + 34);
      repeat (5) @(negedge clk);
      drive(8'd7, 4'd0, 32'd9, 32'd9);
      repeat (5) @(negedge clk);
      drive(8'd8, 4'd0, 32'd1, 32'd1);
      push(8'd8, 32'd2, 1'b0, 1'b0, 32'd0, c0 + 37);
      while (cyc < c0 + 33) @(negedge clk);
      check("mul_busy_last_cycle", {30'd0, status_word[1:0]}, 32'd1);
      wait_drain();

      issue(8'h10, 4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 32'd0, 34);
      issue(8'h11, 4'd2, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 32'd0, 34);
      issue(8'h20, 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b1, 32'd0, 3);
      check("sat_add_result", sat_result, 32'hFFFF_FFFF);
      issue(8'h21, 4'd9, 32'd77, 32'd88, 32'd1, 1'b1, 1'b0, 32'd0, 3);
      issue(8'h23, 4'd3, 32'd100, 32'd0, 32'd100, 1'b0, 1'b0, 32'd100, 3);

      // Reset in the middle of a MUL, then re-accept the same tag.
      @(negedge clk);
      drive(8'h24, 4'd2, 32'h1234, 32'h10);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_status", status_word, 32'd0);
      check("midreset_result", result_word, 32'd0);
      check("midreset_acc", acc_word, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(8'h24, 32'h0001_2340, 1'b0, 1'b0, 32'd0, cyc + 34);
      wait_drain();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
